// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one 1-bit full adder, LSB-first over W clocks,
// with a carry flip-flop and a shift register that assembles the sum.
module serial_adder_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   ra_q, rb_q, sum_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q, cout_q, ovf_q;
    logic           accept, last;
    logic           fa_s, fa_co;

    // The shared 1-bit full adder sees only the current LSBs and the carry flop.
    assign fa_s  = ra_q[0] ^ rb_q[0] ^ carry_q;
    assign fa_co = (ra_q[0] & rb_q[0]) | (carry_q & (ra_q[0] ^ rb_q[0]));

    assign last = (state_q == StRun) && (cnt_q == CW'(W - 1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last) state_d = StDone;
            end
            StDone: begin
                accept  = start;
                state_d = start ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert B here and seed the carry with sub.
            ra_q    <= a;
            rb_q    <= b ^ {W{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            sum_q   <= {fa_s, sum_q[W-1:1]};
            carry_q <= fa_co;
            ra_q    <= {1'b0, ra_q[W-1:1]};
            rb_q    <= {1'b0, rb_q[W-1:1]};
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                ovf_q  <= carry_q ^ fa_co;
                cout_q <= fa_co;
            end
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed table and corner sequences at W=8,
// then randomised operations at W=2, 8 and 16 against an arithmetic reference model.
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;
    logic        sub_c = 1'b0;
    logic [31:0] a_c = '0;
    logic [31:0] b_c = '0;
    logic [2:0]  busy_v, done_v, cout_v, ovf_v;
    logic [1:0]  sum2;
    logic [7:0]  sum8;
    logic [15:0] sum16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.W(2)) u_w2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_c), .a(a_c[1:0]), .b(b_c[1:0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum2), .cout(cout_v[0]), .ovf(ovf_v[0])
    );
    serial_adder_ctrl #(.W(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_c), .a(a_c[7:0]), .b(b_c[7:0]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum8), .cout(cout_v[1]), .ovf(ovf_v[1])
    );
    serial_adder_ctrl #(.W(16)) u_w16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_c), .a(a_c[15:0]), .b(b_c[15:0]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum16), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    function automatic int width_of(input int idx);
        case (idx)
            0:       return 2;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int idx);
        case (idx)
            0:       return {30'b0, sum2};
            1:       return {24'b0, sum8};
            default: return {16'b0, sum16};
        endcase
    endfunction

    // Reference: plain modular and signed arithmetic on the operand values.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, output logic [31:0] s, output logic co,
                                  output logic ov);
        longint md, lim, ua, ub, sa, sb, r;
        md  = longint'(1) << w;
        lim = md / 2;
        ua  = longint'({32'b0, a}) & (md - 1);
        ub  = longint'({32'b0, b}) & (md - 1);
        sa  = (ua >= lim) ? ua - md : ua;
        sb  = (ub >= lim) ? ub - md : ub;
        r   = sub ? sa - sb : sa + sb;
        s   = 32'((sub ? ua - ub : ua + ub) & (md - 1));
        co  = sub ? (ua >= ub) : (ua + ub >= md);
        ov  = (r >= lim) || (r < -lim);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic sub);
        start_v[idx] = 1'b1;
        a_c = a;
        b_c = b;
        sub_c = sub;
        cyc();
        start_v[idx] = 1'b0;
    endtask

    // Counts edges after the accept edge until done; optional junk requests while busy.
    task automatic wait_done(input int idx, input bit noise, output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (done_v[idx]) begin
                lat = n;
                break;
            end
            if (noise) begin
                start_v[idx] = 1'($urandom_range(0, 1));
                a_c = $urandom;
                b_c = $urandom;
                sub_c = 1'($urandom_range(0, 1));
            end
        end
        start_v[idx] = 1'b0;
    endtask

    task automatic run_check(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] b, input logic sub, input bit noise,
                             input logic [31:0] es, input logic eco, input logic eov);
        int lat;
        launch(idx, a, b, sub);
        chk({tag, " busy_after_accept"}, {31'b0, busy_v[idx]}, 32'd1);
        wait_done(idx, noise, lat);
        chk({tag, " latency"}, lat, width_of(idx));
        chk({tag, " sum"}, get_sum(idx), es);
        chk({tag, " cout"}, {31'b0, cout_v[idx]}, {31'b0, eco});
        chk({tag, " ovf"}, {31'b0, ovf_v[idx]}, {31'b0, eov});
        chk({tag, " busy_in_done"}, {31'b0, busy_v[idx]}, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        int lat;
        bit seen;
        logic [31:0] es, m, ra, rb;
        logic eco, eov, rs;

        tbl[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[1] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[2] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};

        repeat (3) cyc();
        chk("reset busy", {29'b0, busy_v}, 32'd0);
        chk("reset done", {29'b0, done_v}, 32'd0);
        chk("reset sum8", {24'b0, sum8}, 32'd0);
        chk("reset cout/ovf", {26'b0, cout_v, ovf_v}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        foreach (tbl[i]) begin
            run_check($sformatf("tbl%0d", i), 1, {24'b0, tbl[i].a}, {24'b0, tbl[i].b},
                      tbl[i].sub, 1'b0, {24'b0, tbl[i].s}, tbl[i].co, tbl[i].ov);
            cyc();
            chk($sformatf("tbl%0d done_one_cycle", i), {31'b0, done_v[1]}, 32'd0);
            chk($sformatf("tbl%0d sum_held", i), {24'b0, sum8}, {24'b0, tbl[i].s});
        end

        // start pulsed mid-run with different operands must be ignored
        launch(1, 32'h7F, 32'h01, 1'b0);
        repeat (3) cyc();
        start_v[1] = 1'b1;
        a_c = 32'h11;
        b_c = 32'h22;
        sub_c = 1'b1;
        cyc();
        start_v[1] = 1'b0;
        wait_done(1, 1'b0, lat);
        chk("ignore latency", lat + 4, 32'd8);
        chk("ignore sum", {24'b0, sum8}, 32'h80);
        chk("ignore ovf", {31'b0, ovf_v[1]}, 32'd1);
        cyc();

        // reset mid-run clears outputs at once and produces no done
        launch(1, 32'hFF, 32'h01, 1'b0);
        repeat (4) cyc();
        #2 rst = 1'b1;
        #1;
        chk("midrst sum", {24'b0, sum8}, 32'd0);
        chk("midrst busy/done", {30'b0, busy_v[1], done_v[1]}, 32'd0);
        chk("midrst cout/ovf", {30'b0, cout_v[1], ovf_v[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            cyc();
            if (done_v[1]) seen = 1'b1;
        end
        chk("midrst no_done", {31'b0, seen}, 32'd0);
        run_check("after_rst", 1, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        // back-to-back: start held in the done cycle, no idle gap
        cyc();
        run_check("b2b first", 1, 32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0);
        launch(1, 32'h50, 32'h30, 1'b1);
        chk("b2b no_gap busy", {31'b0, busy_v[1]}, 32'd1);
        chk("b2b no_gap done", {31'b0, done_v[1]}, 32'd0);
        wait_done(1, 1'b0, lat);
        chk("b2b done_spacing", lat + 1, 32'd9);
        chk("b2b sum", {24'b0, sum8}, 32'h20);
        chk("b2b cout", {31'b0, cout_v[1]}, 32'd1);

        for (int idx = 0; idx < 3; idx++) begin
            m = (32'd1 << width_of(idx)) - 32'd1;
            cyc();
            for (int k = 0; k < 1000; k++) begin
                ra = $urandom & m;
                rb = $urandom & m;
                rs = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) cyc();
                model(width_of(idx), ra, rb, rs, es, eco, eov);
                run_check($sformatf("rnd w%0d #%0d a=%0h b=%0h sub=%0b", width_of(idx), k,
                                    ra, rb, rs), idx, ra, rb, rs, 1'b1, es, eco, eov);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
